// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM arbiter: geometry, grant encoding, write-entry layout.
package vram_pkg;

    localparam int unsigned ROW_W    = 9;
    localparam int unsigned COL_W    = 10;
    localparam int unsigned DATA_W   = 12;
    localparam int unsigned FIFO_AW  = 3;
    localparam int unsigned ADDR_W   = ROW_W + COL_W;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    localparam logic [FIFO_AW:0] FIFO_DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } grant_e;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    function automatic logic in_range(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        return (row < ROW_W'(V_ACTIVE)) && (col < COL_W'(H_ACTIVE));
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write-entry FIFO, depth 2**AW, with flush; exposes current and next-cycle level.
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int unsigned AW = FIFO_AW
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  logic      i_pop,
    input  logic      i_clr,
    input  wr_entry_t i_wdata,
    output wr_entry_t o_rdata,
    output logic      o_empty,
    output logic [AW:0] o_level,
    output logic [AW:0] o_level_next
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    wr_entry_t   r_mem [2**AW];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [AW:0] w_wptr_next;
    logic [AW:0] w_rptr_next;
    logic        w_full;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_level   = r_wptr - r_rptr;
    assign o_empty   = (o_level == '0);
    assign w_full    = (o_level == DEPTH);
    assign w_do_pop  = i_pop && !o_empty;
    // A flush drops any same-cycle push; a same-cycle pop still presents its head entry.
    assign w_do_push = i_push && !i_clr && (!w_full || w_do_pop);
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];

    always_comb begin
        w_wptr_next = r_wptr;
        w_rptr_next = r_rptr;
        if (i_clr) begin
            w_wptr_next = '0;
            w_rptr_next = '0;
        end else begin
            if (w_do_push) w_wptr_next = r_wptr + ONE;
            if (w_do_pop)  w_rptr_next = r_rptr + ONE;
        end
    end

    assign o_level_next = w_wptr_next - w_rptr_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= w_wptr_next;
            r_rptr <= w_rptr_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port pixel RAM arbiter: VGA reads always win, draw writes queue in a FIFO and drain in gaps.
// Optional VRAM_STALL_CNT_EN adds a saturating count of back-pressured write cycles.
module vram_arbiter
    import vram_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_vga_rdn,
    input  logic [ROW_W-1:0]     i_vga_row,
    input  logic [COL_W-1:0]     i_vga_col,
    output logic [DATA_W-1:0]    o_vga_dout,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [ROW_W-1:0]     i_wr_row,
    input  logic [COL_W-1:0]     i_wr_col,
    input  logic [DATA_W-1:0]    i_wr_data,
    input  logic                 i_clr,
    output logic [ADDR_W-1:0]    o_ram_addr,
    output logic                 o_ram_we,
    output logic [DATA_W-1:0]    o_ram_wdata,
    input  logic [DATA_W-1:0]    i_ram_rdata,
    output logic [FIFO_AW:0]     o_fifo_lvl,
    output logic                 o_oob_err
`ifdef VRAM_STALL_CNT_EN
    ,
    output logic [15:0]          o_stall_cnt
`endif
);

    logic               r_wr_ready;
    logic               r_rd_pend;
    logic               r_oob_err;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               w_push;
    logic               w_in_range;
    logic               w_empty;
    logic [FIFO_AW:0]   w_level_next;
    wr_entry_t          w_head;
    wr_entry_t          w_entry;
    grant_e             w_grant;

    assign w_push     = i_wr_valid && r_wr_ready;
    assign w_in_range = in_range(i_wr_row, i_wr_col);
    assign w_entry    = '{row: i_wr_row, col: i_wr_col, data: i_wr_data};
    assign w_grant    = !i_vga_rdn ? READ : (!w_empty ? WRITE : IDLE);

    vram_wr_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_push       (w_push && w_in_range),
        .i_pop        (w_grant == WRITE),
        .i_clr        (i_clr),
        .i_wdata      (w_entry),
        .o_rdata      (w_head),
        .o_empty      (w_empty),
        .o_level      (o_fifo_lvl),
        .o_level_next (w_level_next)
    );

    // Address path is combinational so the VGA sees no extra latency; idle cycles hold the bus.
    always_comb begin
        o_ram_we    = 1'b0;
        o_ram_addr  = r_addr;
        o_ram_wdata = r_wdata;
        unique case (w_grant)
            READ: begin
                o_ram_addr = {i_vga_row, i_vga_col};
            end
            WRITE: begin
                o_ram_we    = 1'b1;
                o_ram_addr  = {w_head.row, w_head.col};
                o_ram_wdata = w_head.data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ready <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_oob_err  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_wr_ready <= (w_level_next != FIFO_DEPTH) && !i_clr;
            r_rd_pend  <= (w_grant == READ);
            r_oob_err  <= r_oob_err || (w_push && !w_in_range);
            r_addr     <= o_ram_addr;
            r_wdata    <= o_ram_wdata;
        end
    end

    assign o_wr_ready = r_wr_ready;
    assign o_oob_err  = r_oob_err;
    assign o_vga_dout = r_rd_pend ? i_ram_rdata : '0;

`ifdef VRAM_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_clr) begin
            r_stall_cnt <= '0;
        end else if (i_wr_valid && !r_wr_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected RAM writes are queued at handshake, a monitor checks them.
`timescale 1ns/1ps
module tb_vram_arbiter;
    import vram_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              vga_rdn;
    logic [ROW_W-1:0]  vga_row;
    logic [COL_W-1:0]  vga_col;
    logic [DATA_W-1:0] vga_dout;
    logic              wr_valid;
    logic              wr_ready;
    logic [ROW_W-1:0]  wr_row;
    logic [COL_W-1:0]  wr_col;
    logic [DATA_W-1:0] wr_data;
    logic              clr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [FIFO_AW:0]  fifo_lvl;
    logic              oob_err;
`ifdef VRAM_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    vram_arbiter u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_vga_rdn   (vga_rdn),
        .i_vga_row   (vga_row),
        .i_vga_col   (vga_col),
        .o_vga_dout  (vga_dout),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_row    (wr_row),
        .i_wr_col    (wr_col),
        .i_wr_data   (wr_data),
        .i_clr       (clr),
        .o_ram_addr  (ram_addr),
        .o_ram_we    (ram_we),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_fifo_lvl  (fifo_lvl),
        .o_oob_err   (oob_err)
`ifdef VRAM_STALL_CNT_EN
        ,
        .o_stall_cnt (stall_cnt)
`endif
    );

    always #20 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wexp_t;

    wexp_t wq[$];
    wexp_t mon_e;
    logic              prev_rd = 1'b0;
    logic [DATA_W-1:0] prev_exp = '0;

    function automatic logic [DATA_W-1:0] ram_model(input logic [ADDR_W-1:0] a);
        return a[DATA_W-1:0] ^ 12'hABC;
    endfunction

    // Synchronous RAM stand-in: data for an address appears one cycle later.
    always @(posedge clk) ram_rdata <= ram_model(ram_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 1'b0;
        end else begin
            if (prev_rd) check("vga_dout", 32'(vga_dout), 32'(prev_exp));
            else         check("vga_dout_idle", 32'(vga_dout), 32'd0);
            if (!vga_rdn) begin
                check("read_no_we", 32'(ram_we), 32'd0);
                check("read_addr", 32'(ram_addr), 32'({vga_row, vga_col}));
                prev_rd  = 1'b1;
                prev_exp = ram_model({vga_row, vga_col});
            end else begin
                prev_rd = 1'b0;
            end
            if (ram_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0h data=%0h required=no_write",
                             ram_addr, ram_wdata);
                end else begin
                    mon_e = wq.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(mon_e.addr));
                    check("wr_data", 32'(ram_wdata), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int row, input int col, input int data, input bit written);
        int n;
        wr_row   = ROW_W'(row);
        wr_col   = COL_W'(col);
        wr_data  = DATA_W'(data);
        wr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!wr_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!wr_ready) begin
            failures++;
            $display("FAIL wr_handshake_timeout actual=wr_ready_0 required=wr_ready_1");
        end else if (written) begin
            wq.push_back({ROW_W'(row), COL_W'(col), DATA_W'(data)});
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (wq.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("drain_pending", 32'(wq.size()), 32'd0);
    endtask

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; vga_rdn = 1'b1; vga_row = '0; vga_col = '0;
        wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; clr = 1'b0;
        #5;
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_vga_dout", 32'(vga_dout), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_fifo_lvl", 32'(fifo_lvl), 32'd0);
        check("rst_oob_err", 32'(oob_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("wr_ready_after_reset", 32'(wr_ready), 32'd1);

        // 1: three back-to-back writes, no bypass, one pop per cycle
        sync();
        wr_row = 9'd1; wr_col = 10'd2; wr_data = 12'h111; wr_valid = 1'b1;
        wq.push_back({9'd1, 10'd2, 12'h111});
        @(negedge clk); check("t1_no_bypass", 32'(ram_we), 32'd0);
        sync();
        wr_row = 9'd3; wr_col = 10'd4; wr_data = 12'h222;
        wq.push_back({9'd3, 10'd4, 12'h222});
        @(negedge clk); check("t1_we_0", 32'(ram_we), 32'd1);
        sync();
        wr_row = 9'd479; wr_col = 10'd639; wr_data = 12'h333;
        wq.push_back({9'd479, 10'd639, 12'h333});
        @(negedge clk); check("t1_we_1", 32'(ram_we), 32'd1);
        sync();
        wr_valid = 1'b0;
        @(negedge clk); check("t1_we_2", 32'(ram_we), 32'd1);
        @(negedge clk); check("t1_we_end", 32'(ram_we), 32'd0);
        check("t1_idle_addr_hold", 32'(ram_addr), 32'({9'd479, 10'd639}));
        wait_drain();

        // 2: reads take priority over 4 queued writes
        sync();
        vga_rdn = 1'b0; vga_row = 9'd4; vga_col = 10'd0;
        for (int i = 0; i < 4; i++) do_write(10 + i, 100 + i, 12'h700 + i, 1'b1);
        @(negedge clk); check("t2_lvl4", 32'(fifo_lvl), 32'd4);
        sync();
        vga_row = 9'd10; vga_col = 10'd20;
        @(negedge clk); check("t2_addr_track", 32'(ram_addr), 32'({9'd10, 10'd20}));
        sync();
        vga_row = 9'd4; vga_col = 10'd0;
        @(negedge clk);
        @(negedge clk); check("t2_dout_abc", 32'(vga_dout), 32'h0ABC);
        sync();
        vga_rdn = 1'b1;
        wait_drain();
        @(negedge clk); check("t2_lvl0", 32'(fifo_lvl), 32'd0);

        // 3: fill under continuous reads; ninth write waits for a pop
        sync();
        vga_rdn = 1'b0;
        for (int i = 0; i < 8; i++) do_write(20 + i, 3 * i, 12'h500 + i, 1'b1);
        @(negedge clk);
        check("t3_full_ready", 32'(wr_ready), 32'd0);
        check("t3_lvl8", 32'(fifo_lvl), 32'd8);
        fork
            do_write(100, 100, 12'hFFF, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t3_hold_ready", 32'(wr_ready), 32'd0);
                    check("t3_hold_lvl", 32'(fifo_lvl), 32'd8);
                end
                sync();
                vga_rdn = 1'b1;
            end
        join
        wait_drain();

        // 4: out-of-range writes are accepted but discarded
        @(negedge clk); check("t4_oob_clear", 32'(oob_err), 32'd0);
        sync();
        do_write(480, 5, 12'h0AA, 1'b0);
        do_write(0, 640, 12'h0BB, 1'b0);
        @(negedge clk);
        check("t4_oob_set", 32'(oob_err), 32'd1);
        check("t4_lvl0", 32'(fifo_lvl), 32'd0);
        repeat (5) @(negedge clk);
        check("t4_oob_sticky", 32'(oob_err), 32'd1);

        // 5: flush with 5 entries and a simultaneous push
        sync();
        vga_rdn = 1'b0;
        for (int i = 0; i < 5; i++) do_write(200 + i, 300 + i, 12'h900 + i, 1'b0);
        @(negedge clk); check("t5_lvl5", 32'(fifo_lvl), 32'd5);
        sync();
        clr = 1'b1; wr_valid = 1'b1; wr_row = 9'd7; wr_col = 10'd7; wr_data = 12'h777;
        sync();
        clr = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        check("t5_lvl_flushed", 32'(fifo_lvl), 32'd0);
        check("t5_ready_low", 32'(wr_ready), 32'd0);
        sync();
        vga_rdn = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_lvl_still0", 32'(fifo_lvl), 32'd0);
        check("t5_oob_sticky", 32'(oob_err), 32'd1);

        // 6: optional stall counter, then reset while the FIFO drains
        sync();
        vga_rdn = 1'b0;
`ifdef VRAM_STALL_CNT_EN
        clr = 1'b1;
        sync();
        clr = 1'b0;
        repeat (2) sync();
        @(negedge clk); check("t6_stall_zero", 32'(stall_cnt), 32'd0);
        sync();
        for (int i = 0; i < 8; i++) do_write(30 + i, 40 + i, 12'h300 + i, 1'b1);
        wr_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        wr_valid = 1'b0;
        @(negedge clk); check("t6_stall_cnt", 32'(stall_cnt), 32'd10);
`else
        for (int i = 0; i < 6; i++) do_write(30 + i, 40 + i, 12'h300 + i, 1'b1);
`endif
        sync();
        vga_rdn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_we", 32'(ram_we), 32'd0);
        check("t6_rst_lvl", 32'(fifo_lvl), 32'd0);
        check("t6_rst_ready", 32'(wr_ready), 32'd0);
        check("t6_rst_oob", 32'(oob_err), 32'd0);
`ifdef VRAM_STALL_CNT_EN
        check("t6_rst_stall", 32'(stall_cnt), 32'd0);
`endif
        wq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_post_rst_lvl", 32'(fifo_lvl), 32'd0);
        sync();
        do_write(5, 5, 12'h123, 1'b1);
        wait_drain();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
